// File: rtl/vga_draw_pkg.sv
// Shared constants for the VGA draw arbiter: FSM encodings, default widths, screen size.
package vga_draw_pkg;
    localparam int X_W_DEF  = 9;
    localparam int Y_W_DEF  = 8;
    localparam int C_W_DEF  = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // A disabled watchdog (limit 0) still needs a 1-bit counter to stay legal.
    function automatic int wd_width(input int limit);
        return (limit <= 0) ? 1 : $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/vga_draw_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin : pick
        int j;
        j     = 0;
        valid = |req;
        idx   = '0;
        // Scan from the far end so the candidate nearest ptr is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) idx = IW'(j);
        end
    end
endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA adapter write port among NUM_REQ start/done drawing engines,
// one grant at a time, round-robin, with a per-grant watchdog.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int X_W            = X_W_DEF,
    parameter int Y_W            = Y_W_DEF,
    parameter int C_W            = C_W_DEF,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         eng_start,
    input  logic [NUM_REQ-1:0]         eng_done,
    input  logic [NUM_REQ*X_W-1:0]     eng_x,
    input  logic [NUM_REQ*Y_W-1:0]     eng_y,
    input  logic [NUM_REQ*C_W-1:0]     eng_colour,
    input  logic [NUM_REQ-1:0]         eng_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    input  logic                       clr_err
);
    // state   | meaning
    // IDLE    | waiting for any req; picks next engine round-robin
    // GRANT   | start raised for picked engine; watchdog cleared
    // RUN     | engine owns the VGA port; exit on done / withdraw / timeout
    // RELEASE | start dropped; rr pointer advanced past this engine

    localparam int IW   = $clog2(NUM_REQ);
    localparam int WD_W = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

    logic [1:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [WD_W-1:0] wd;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            run_done;
    logic            run_wdraw;
    logic            tmo_fire;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign run_done  = eng_done[grant_id];
    assign run_wdraw = !req[grant_id];
    assign tmo_fire  = (TIMEOUT_CYCLES != 0) && (state == ST_RUN) && !run_done
                       && !run_wdraw && (wd == WD_LAST);
    assign busy      = (state != ST_IDLE);

    // Decoded straight from state so reset drops start without waiting for a clock.
    always_comb begin
        eng_start = '0;
        if (state == ST_GRANT || state == ST_RUN) eng_start[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            wd       <= '0;
            req_done <= '0;
        end else begin
            req_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    wd    <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (wd != WD_SAT) wd <= wd + WD_W'(1);
                    if (run_done) begin
                        req_done[grant_id] <= 1'b1;
                        state              <= ST_RELEASE;
                    end else if (run_wdraw || tmo_fire) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        timeout_err <= 1'b0;
        else if (tmo_fire) timeout_err <= 1'b1;
        else if (clr_err)  timeout_err <= 1'b0;
    end

    // Output mux: coordinates hold outside RUN, plot strobe forced low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (state == ST_RUN) begin
            vga_x      <= eng_x[grant_id*X_W +: X_W];
            vga_y      <= eng_y[grant_id*Y_W +: Y_W];
            vga_colour <= eng_colour[grant_id*C_W +: C_W];
            vga_plot   <= eng_plot[grant_id];
        end else begin
            vga_plot <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: per-cycle vector table plus hand-timed corner sequences.
module tb_vga_draw_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_done;
    logic [3:0]  eng_start;
    logic [3:0]  eng_done;
    logic [35:0] eng_x;
    logic [31:0] eng_y;
    logic [11:0] eng_colour;
    logic [3:0]  eng_plot = '0;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    logic [8:0] ex [4];
    logic [7:0] ey [4];
    logic [2:0] ec [4];
    logic       auto_en = 1'b0;
    logic [3:0] man_done = '0;
    logic [3:0] auto_done;
    int         acnt [4];
    int         rd_cnt [4];
    int         overlap_cnt = 0;
    int         n_checks = 0;
    int         n_err = 0;

    vga_draw_arbiter #(.NUM_REQ(4), .X_W(9), .Y_W(8), .C_W(3), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_done(req_done), .eng_start(eng_start),
        .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
        .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        eng_x = '0; eng_y = '0; eng_colour = '0;
        for (int i = 0; i < 4; i++) begin
            eng_x[i*9 +: 9]      = ex[i];
            eng_y[i*8 +: 8]      = ey[i];
            eng_colour[i*3 +: 3] = ec[i];
        end
    end

    // Auto engine: raises done on its third cycle of start, drops everything when start falls.
    always @(posedge clk)
        for (int i = 0; i < 4; i++) acnt[i] <= eng_start[i] ? acnt[i] + 1 : 0;
    always_comb begin
        auto_done = '0;
        for (int i = 0; i < 4; i++) auto_done[i] = eng_start[i] && (acnt[i] >= 2);
    end
    assign eng_done = auto_en ? auto_done : man_done;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (req_done[i]) rd_cnt[i] = rd_cnt[i] + 1;
        if (!$onehot0(eng_start)) overlap_cnt = overlap_cnt + 1;
    end

    typedef struct {
        logic [3:0] rq, dn, pl;
        logic [8:0] x;  logic [7:0] y;  logic [2:0] c;
        logic [3:0] e_start, e_rdone;
        logic       e_plot;
        logic [8:0] e_x; logic [7:0] e_y; logic [2:0] e_c;
        logic       e_busy;
        logic [1:0] e_gid;
    } vec_t;
    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] rq, dn, pl, input logic [8:0] x,
                                input logic [7:0] y, input logic [2:0] c,
                                input logic [3:0] es, erd, input logic ep, input logic [8:0] exx,
                                input logic [7:0] eyy, input logic [2:0] ecc,
                                input logic eb, input logic [1:0] eg);
        vec_t v;
        v.rq = rq; v.dn = dn; v.pl = pl; v.x = x; v.y = y; v.c = c;
        v.e_start = es; v.e_rdone = erd; v.e_plot = ep; v.e_x = exx; v.e_y = eyy; v.e_c = ecc;
        v.e_busy = eb; v.e_gid = eg;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; man_done = '0; eng_plot = '0; clr_err = 1'b0; auto_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int base, n, gap;
        for (int i = 0; i < 4; i++) begin
            ex[i] = 9'(400 + i); ey[i] = 8'(200 + i); ec[i] = 3'd7; rd_cnt[i] = 0;
        end

        // Single engine 1: plots, then done with a final plot on its 10th RUN cycle.
        tbl[0]  = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 1);
        tbl[1]  = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 4'b0010, 4'b0000, 1, 1, 1, 1, 1, 1);
        tbl[3]  = mk(4'b0010, 4'b0000, 4'b0000, 1, 1, 1, 4'b0010, 4'b0000, 0, 1, 1, 1, 1, 1);
        tbl[4]  = mk(4'b0010, 4'b0000, 4'b0010, 2, 3, 4, 4'b0010, 4'b0000, 1, 2, 3, 4, 1, 1);
        for (int i = 5; i <= 10; i++)
            tbl[i] = mk(4'b0010, 4'b0000, 4'b0000, 2, 3, 4, 4'b0010, 4'b0000, 0, 2, 3, 4, 1, 1);
        tbl[11] = mk(4'b0010, 4'b0010, 4'b0010, 5, 7, 2, 4'b0000, 4'b0010, 1, 5, 7, 2, 1, 1);
        tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 5, 7, 2, 4'b0000, 4'b0000, 0, 5, 7, 2, 0, 1);
        tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 5, 7, 2, 4'b0000, 4'b0000, 0, 5, 7, 2, 0, 1);

        do_reset();
        check("reset_outputs", {eng_start, req_done, vga_plot, vga_x, vga_y, vga_colour,
                                busy, grant_id, timeout_err}, 64'd0);

        base = rd_cnt[1];
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].rq; man_done = tbl[i].dn; eng_plot = tbl[i].pl;
            ex[1] = tbl[i].x; ey[1] = tbl[i].y; ec[1] = tbl[i].c;
            step(1);
            check($sformatf("vec%0d", i),
                  {eng_start, req_done, vga_plot, vga_x, vga_y, vga_colour, busy, grant_id},
                  {tbl[i].e_start, tbl[i].e_rdone, tbl[i].e_plot, tbl[i].e_x, tbl[i].e_y,
                   tbl[i].e_c, tbl[i].e_busy, tbl[i].e_gid});
        end
        check("single_req_done_once", 64'(rd_cnt[1] - base), 64'd1);

        // All four requesting: round-robin order 0,1,2,3,0 with a 2-cycle start-low gap.
        do_reset();
        auto_en = 1'b1; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (eng_start == 4'b0000 && n < 20) begin step(1); n++; end
            check($sformatf("rr_grant%0d", g), {eng_start, 2'b00, grant_id},
                  {4'(1 << (g % 4)), 2'b00, 2'(g % 4)});
            n = 0;
            while (eng_start != 4'b0000 && n < 20) begin step(1); n++; end
            if (g < 4) begin
                gap = 0;
                while (eng_start == 4'b0000 && gap < 20) begin step(1); gap++; end
                check($sformatf("rr_gap%0d", g), 64'(gap >= 2), 64'd1);
            end
        end
        req = '0; auto_en = 1'b0;
        step(4);

        // Engine 2 plotting while engine 0 owns the port must not leak through.
        do_reset();
        ex[0] = 10; ey[0] = 20; ec[0] = 3;
        ex[2] = 99; ey[2] = 88; ec[2] = 6;
        eng_plot = 4'b0100; req = 4'b0001;
        step(3);
        check("nongrant_ignored", {vga_plot, vga_x, vga_y, vga_colour}, {1'b0, 9'd10, 8'd20, 3'd3});
        ex[0] = 11; ey[0] = 21; ec[0] = 1; eng_plot = 4'b0101;
        step(1);
        check("granted_plot", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 9'd11, 8'd21, 3'd1});
        req = '0; eng_plot = '0;
        step(3);

        // Withdrawal of req[3] mid-RUN.
        do_reset();
        base = rd_cnt[3];
        req = 4'b1000;
        step(3);
        req = 4'b0000;
        step(1);
        check("withdraw_release", {eng_start, req_done, busy}, {4'b0000, 4'b0000, 1'b1});
        step(1);
        check("withdraw_idle", {eng_start, req_done, busy}, {4'b0000, 4'b0000, 1'b0});
        check("withdraw_no_done", 64'(rd_cnt[3] - base), 64'd0);

        // Watchdog: engine 0 hangs, aborted after 16 RUN cycles, engine 1 granted next.
        do_reset();
        base = rd_cnt[0];
        req = 4'b0011;
        step(17);
        check("wd_still_running", {eng_start, timeout_err}, {4'b0001, 1'b0});
        step(1);
        check("wd_abort", {eng_start, timeout_err, req_done, busy}, {4'b0000, 1'b1, 4'b0000, 1'b1});
        step(2);
        check("wd_next_grant", {eng_start, grant_id}, {4'b0010, 2'd1});
        req = '0;
        step(3);
        check("wd_sticky", 64'(timeout_err), 64'd1);
        check("wd_no_done", 64'(rd_cnt[0] - base), 64'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("clr_err", 64'(timeout_err), 64'd0);

        // Watchdog firing while clr_err is held: set must win.
        clr_err = 1'b1; req = 4'b0100;
        n = 0;
        while (eng_start == 4'b0000 && n < 10) begin step(1); n++; end
        n = 0;
        while (eng_start != 4'b0000 && n < 40) begin step(1); n++; end
        check("set_wins_over_clr", {timeout_err, eng_start}, {1'b1, 4'b0000});
        clr_err = 1'b0; req = '0;
        step(3);

        // Async reset mid-RUN, then the pointer must be back at 0.
        do_reset();
        auto_en = 1'b1; req = 4'b0100;
        n = 0;
        while (req_done[2] == 1'b0 && n < 30) begin step(1); n++; end
        req = 4'b1100;
        n = 0;
        while (eng_start == 4'b0000 && n < 10) begin step(1); n++; end
        check("pre_reset_grant3", {eng_start, grant_id}, {4'b1000, 2'd3});
        auto_en = 1'b0; man_done = '0;
        ex[3] = 33; ey[3] = 44; ec[3] = 5; eng_plot = 4'b1000;
        step(2);
        check("pre_reset_plot", {vga_plot, vga_x}, {1'b1, 9'd33});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {eng_start, req_done, vga_plot, vga_x, vga_y, vga_colour,
                                      busy, grant_id, timeout_err}, 64'd0);
        eng_plot = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("post_reset_ptr0", {eng_start, grant_id}, {4'b0100, 2'd2});
        req = '0;
        step(4);

        check("no_overlap", 64'(overlap_cnt), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
